dmem_arbiter: RTL and testbench

- Shares one single-port data memory (synchronous read, 1-cycle read latency, byte-enable writes) between two requesters: m0 = CPU load/store unit, m1 = loader/debug/DMA master.
- Round-robin grant, one access per cycle. Handles store lane alignment, load extraction with sign/zero extension, and misalignment/illegal-op errors.
- Sits between the masters and the memory macro.

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_lane_fmt.sv | 32 +++
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the memop encodings, byte-lane base patterns, the registered
// response record and helpers for legality and lane-enable decoding.
package dmem_pkg;

   localparam logic [2:0] MOP_B  = 3'b000;
   localparam logic [2:0] MOP_H  = 3'b001;
   localparam logic [2:0] MOP_W  = 3'b010;
   localparam logic [2:0] MOP_BU = 3'b100;
   localparam logic [2:0] MOP_HU = 3'b101;

   // Lane enables for an access at byte offset 0; shifted by addr[1:0] on use.
   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;

   // State carried from the grant cycle into the response cycle.
   typedef struct packed {
      logic       valid;
      logic       id;
      logic       we;
      logic [2:0] memop;
      logic [1:0] addr_lo;
      logic       err;
   } rsp_t;

   // Legal encoding and natural alignment for the access size.
   function automatic logic mop_legal(input logic [2:0] memop, input logic [1:0] addr_lo);
      logic ok;
      case (memop)
         MOP_B, MOP_BU: ok = 1'b1;
         MOP_H, MOP_HU: ok = ~addr_lo[0];
         MOP_W:         ok = (addr_lo == 2'b00);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] mop_lanes(input logic [2:0] memop);
      logic [3:0] lanes;
      case (memop)
         MOP_B, MOP_BU: lanes = LANE_B;
         MOP_H, MOP_HU: lanes = LANE_H;
         MOP_W:         lanes = LANE_W;
         default:       lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's port on the data-memory arbiter.
//   req/we/addr/wdata/memop : request, held by the master until gnt
//   gnt                     : accept in the current cycle
//   rvalid/rdata/err        : response strobe one cycle after gnt
interface dmem_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  memop;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, we, addr, wdata, memop,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata, memop,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Load-data formatter: picks the addressed byte/halfword out of the memory
// word and sign- or zero-extends it according to memop.
//   memop_i   : memop of the access being answered
//   addr_lo_i : byte offset within the word
//   q_i       : raw memory read word
//   rdata_o   : right-justified, extended load data
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [2:0]  memop_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] q_i,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'(q_i >> {addr_lo_i, 3'b000});
      half_v = addr_lo_i[1] ? q_i[31:16] : q_i[15:0];
      case (memop_i)
         MOP_B:   rdata_o = {{24{byte_v[7]}}, byte_v};
         MOP_BU:  rdata_o = {24'h0, byte_v};
         MOP_H:   rdata_o = {{16{half_v[15]}}, half_v};
         MOP_HU:  rdata_o = {16'h0, half_v};
         MOP_W:   rdata_o = q_i;
         default: rdata_o = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous data
// memory. One access per cycle; store lanes are aligned here and load data is
// extracted/extended in the response cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   m0, m1      : requester ports (m0 = CPU LSU, m1 = loader/debug/DMA)
//   mem_*       : memory macro drive; mem_q is read data one cycle later
// The macro must return freshly written data when the same word is written in
// one cycle and read in the next.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W = 15,
   parameter logic [31:0] BASE   = 32'h0010_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     m0,
   dmem_arbiter_if.slave     m1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_byteena,
   output logic              mem_we,
   input  logic [31:0]       mem_q
);

   // rr_ptr holds the last granted id; on a tie the other master wins.
   logic rr_ptr_q, rr_ptr_d;
   rsp_t rsp_q, rsp_d;

   logic        gnt0, gnt1, any_gnt, sel;
   logic        sel_we;
   logic [31:0] sel_addr, sel_wdata;
   logic [2:0]  sel_mop;
   logic        sel_err;
   logic [31:0] fmt_rdata;

   always_comb begin
      // rst_n gating keeps grants off while the async reset is asserted.
      gnt0    = rst_n & m0.req & (~m1.req | rr_ptr_q);
      gnt1    = rst_n & m1.req & (~m0.req | ~rr_ptr_q);
      any_gnt = gnt0 | gnt1;
      sel     = gnt1;

      sel_we    = sel ? m1.we    : m0.we;
      sel_addr  = sel ? m1.addr  : m0.addr;
      sel_wdata = sel ? m1.wdata : m0.wdata;
      sel_mop   = sel ? m1.memop : m0.memop;

      sel_err = ~mop_legal(sel_mop, sel_addr[1:0]) |
                (sel_addr[31:ADDR_W+2] != BASE[31:ADDR_W+2]);

      mem_addr    = sel_addr[ADDR_W+1:2];
      mem_byteena = mop_lanes(sel_mop) << sel_addr[1:0];
      mem_wdata   = sel_wdata << {sel_addr[1:0], 3'b000};
      mem_we      = any_gnt & sel_we & ~sel_err;

      m0.gnt = gnt0;
      m1.gnt = gnt1;

      rr_ptr_d = any_gnt ? sel : rr_ptr_q;

      rsp_d         = '0;
      rsp_d.valid   = any_gnt;
      rsp_d.id      = sel;
      rsp_d.we      = sel_we;
      rsp_d.memop   = sel_mop;
      rsp_d.addr_lo = sel_addr[1:0];
      rsp_d.err     = sel_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= 1'b1;
         rsp_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rsp_q    <= rsp_d;
      end
   end

   dmem_lane_fmt u_lane_fmt (
      .memop_i   (rsp_q.memop),
      .addr_lo_i (rsp_q.addr_lo),
      .q_i       (mem_q),
      .rdata_o   (fmt_rdata)
   );

   // Stores and errored accesses answer with zero data.
   always_comb begin
      m0.rvalid = rsp_q.valid & ~rsp_q.id;
      m1.rvalid = rsp_q.valid & rsp_q.id;
      m0.err    = m0.rvalid & rsp_q.err;
      m1.err    = m1.rvalid & rsp_q.err;
      m0.rdata  = (m0.rvalid & ~rsp_q.we & ~rsp_q.err) ? fmt_rdata : '0;
      m1.rdata  = (m1.rvalid & ~rsp_q.we & ~rsp_q.err) ? fmt_rdata : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a byte-addressed reference memory.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int unsigned ADDR_W = 15;
   localparam logic [31:0] BASE   = 32'h0010_0000;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_byteena;
   logic              mem_we;
   logic [31:0]       mem_q;

   logic              q_ovr_en;
   logic [31:0]       q_ovr;
   logic [31:0]       model_q;
   logic [31:0]       merged;
   logic [31:0]       mem_arr [0:(1<<ADDR_W)-1];
   logic [7:0]        ref_bytes [0:63];

   int checks = 0;
   int errors = 0;

   dmem_arbiter_if m0_if ();
   dmem_arbiter_if m1_if ();

   dmem_arbiter #(
      .ADDR_W (ADDR_W),
      .BASE   (BASE)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_byteena (mem_byteena),
      .mem_we      (mem_we),
      .mem_q       (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory macro model: byte-enable write, write-then-read, 1-cycle read.
   always_comb begin
      merged = mem_arr[mem_addr];
      for (int b = 0; b < 4; b++)
         if (mem_byteena[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
      end else if (mem_we) begin
         mem_arr[mem_addr] <= merged;
      end
      model_q <= mem_we ? merged : mem_arr[mem_addr];
   end

   assign mem_q = q_ovr_en ? q_ovr : model_q;

   task automatic drive(input bit id, input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] mop);
      if (!id) begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
         m0_if.memop = mop;
      end else begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
         m1_if.memop = mop;
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, MOP_B);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, MOP_B);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b1, BASE, 32'h1, MOP_W);
      drive(1'b1, 1'b1, 1'b1, BASE, 32'h2, MOP_W);
      #1;
      checks++; if (m0_if.gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt got=%b exp=0", m0_if.gnt); end
      checks++; if (m1_if.gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt got=%b exp=0", m1_if.gnt); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      @(posedge clk); #1;
      checks++; if ({m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err} !== 4'b0) begin
         errors++; $display("FAIL rst_rsp got=%b exp=0000", {m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err});
      end
      checks++; if ((m0_if.rdata | m1_if.rdata) !== 32'h0) begin
         errors++; $display("FAIL rst_rdata got=%h/%h exp=0", m0_if.rdata, m1_if.rdata);
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_load_word();
      @(negedge clk);
      q_ovr_en = 1'b1; q_ovr = 32'hDEAD_BEEF;
      drive(1'b0, 1'b1, 1'b0, BASE + 32'h10, 32'h0, MOP_W);
      #1;
      checks++; if ({m0_if.gnt, m1_if.gnt} !== 2'b10) begin errors++; $display("FAIL lw_gnt got=%b exp=10", {m0_if.gnt, m1_if.gnt}); end
      checks++; if (mem_addr !== 15'd4) begin errors++; $display("FAIL lw_addr got=%h exp=4", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lw_we got=%b exp=0", mem_we); end
      @(negedge clk);
      idle();
      #1;
      checks++; if ({m0_if.rvalid, m1_if.rvalid, m0_if.err} !== 3'b100) begin
         errors++; $display("FAIL lw_rvalid got=%b exp=100", {m0_if.rvalid, m1_if.rvalid, m0_if.err});
      end
      checks++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", m0_if.rdata); end
   endtask

   task automatic test_store_byte();
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, BASE + 32'h3, 32'h0000_00A5, MOP_B);
      #1;
      checks++; if (m1_if.gnt !== 1'b1) begin errors++; $display("FAIL sb_gnt got=%b exp=1", m1_if.gnt); end
      checks++; if (mem_byteena !== 4'b1000) begin errors++; $display("FAIL sb_be got=%b exp=1000", mem_byteena); end
      checks++; if (mem_wdata !== 32'hA500_0000) begin errors++; $display("FAIL sb_wdata got=%h exp=a5000000", mem_wdata); end
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_we got=%b exp=1", mem_we); end
      @(negedge clk);
      q_ovr = 32'hA500_0000;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, MOP_B);
      drive(1'b0, 1'b1, 1'b0, BASE + 32'h3, 32'h0, MOP_B);
      #1;
      checks++; if ({m1_if.rvalid, m1_if.err, m0_if.rvalid} !== 3'b100) begin
         errors++; $display("FAIL sb_ack got=%b exp=100", {m1_if.rvalid, m1_if.err, m0_if.rvalid});
      end
      checks++; if (m1_if.rdata !== 32'h0) begin errors++; $display("FAIL sb_ack_rdata got=%h exp=0", m1_if.rdata); end
      checks++; if (m0_if.gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lb_gnt got=%b%b exp=10", m0_if.gnt, mem_we); end
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, BASE + 32'h3, 32'h0, MOP_BU);
      #1;
      checks++; if (m0_if.rdata !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffffa5", m0_if.rdata); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (m0_if.rdata !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_rdata got=%h exp=000000a5", m0_if.rdata); end
   endtask

   task automatic test_halfword();
      logic [31:0] addr_t [4] = '{BASE + 32'h2, BASE + 32'h2, BASE + 32'h0, BASE + 32'h1};
      logic [2:0]  mop_t  [4] = '{MOP_HU, MOP_H, MOP_H, MOP_B};
      logic [31:0] exp_t  [4] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_1234, 32'h0000_0012};
      q_ovr = 32'h8001_1234;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) drive(1'b0, 1'b1, 1'b0, addr_t[i], 32'h0, mop_t[i]);
         else idle();
         #1;
         if (i > 0) begin
            checks++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== exp_t[i-1]) begin
               errors++; $display("FAIL half_%0d got=%b/%h exp=1/%h", i - 1, m0_if.rvalid, m0_if.rdata, exp_t[i-1]);
            end
         end
      end
   endtask

   task automatic test_misalign();
      logic [31:0] addr_t [4] = '{BASE + 32'h1, BASE + 32'h2, BASE + 32'h0, 32'h0000_0000};
      logic [2:0]  mop_t  [4] = '{MOP_H, MOP_W, 3'b011, MOP_W};
      q_ovr = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, i[0], addr_t[i>>1], 32'hFFFF_FFFF, mop_t[i>>1]);
         #1;
         checks++; if (m0_if.gnt !== 1'b1 || mem_we !== 1'b0) begin
            errors++; $display("FAIL mis_gnt_%0d got=%b%b exp=10", i, m0_if.gnt, mem_we);
         end
         @(negedge clk);
         idle();
         #1;
         checks++; if ({m0_if.rvalid, m0_if.err} !== 2'b11 || m0_if.rdata !== 32'h0) begin
            errors++; $display("FAIL mis_rsp_%0d got=%b%b/%h exp=11/0", i, m0_if.rvalid, m0_if.err, m0_if.rdata);
         end
      end
   endtask

   task automatic test_round_robin();
      int prev = 0;
      apply_reset();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         q_ovr = 32'h1234_0000 + c;
         if (c < 6) begin
            drive(1'b0, 1'b1, 1'b0, BASE + 32'h0, 32'h0, MOP_W);
            drive(1'b1, 1'b1, 1'b0, BASE + 32'h4, 32'h0, MOP_W);
         end else idle();
         #1;
         if (c < 6) begin
            checks++; if ({m0_if.gnt, m1_if.gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL rr_gnt_%0d got=%b%b exp_id=%0d", c, m0_if.gnt, m1_if.gnt, c % 2);
            end
         end
         if (c > 0) begin
            checks++; if ({m0_if.rvalid, m1_if.rvalid} !== ((prev == 0) ? 2'b10 : 2'b01)) begin
               errors++; $display("FAIL rr_rvalid_%0d got=%b%b exp_id=%0d", c, m0_if.rvalid, m1_if.rvalid, prev);
            end
            checks++; if ((prev == 0 ? m0_if.rdata : m1_if.rdata) !== q_ovr) begin
               errors++; $display("FAIL rr_rdata_%0d got=%h exp=%h", c, prev == 0 ? m0_if.rdata : m1_if.rdata, q_ovr);
            end
         end
         prev = c % 2;
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, MOP_W);
      #1;
      checks++; if (m1_if.gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got=%b exp=1", m1_if.gnt); end
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      #1;
      checks++; if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid got=%b exp=0", m1_if.rvalid); end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, BASE, 32'h0, MOP_W);
      drive(1'b1, 1'b1, 1'b0, BASE, 32'h0, MOP_W);
      #1;
      checks++; if ({m0_if.gnt, m1_if.gnt} !== 2'b10) begin errors++; $display("FAIL rmid_tie got=%b exp=10", {m0_if.gnt, m1_if.gnt}); end
      @(negedge clk);
      #1;
      checks++; if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid} !== 3'b011) begin
         errors++; $display("FAIL rmid_next got=%b exp=011", {m0_if.gnt, m1_if.gnt, m0_if.rvalid});
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_random();
      logic [2:0]  legal_t [5] = '{MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU};
      logic [2:0]  bad_t   [3] = '{3'b011, 3'b110, 3'b111};
      logic        pend [2] = '{1'b0, 1'b0};
      logic        p_we [2];
      logic [31:0] p_addr [2];
      logic [31:0] p_wd [2];
      logic [2:0]  p_mop [2];
      logic        last = 1'b1;
      logic        exp_v = 1'b0, exp_id = 1'b0, exp_err = 1'b0;
      logic [31:0] exp_rd = '0;
      logic        g, any, e_err, we;
      logic [31:0] a, val;
      logic [2:0]  m;
      int          offs, size;
      q_ovr_en = 1'b0;
      for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h0;
      apply_reset();
      for (int cyc = 0; cyc < 401; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && cyc < 400 && $urandom_range(0, 9) < 6) begin
               pend[i]  = 1'b1;
               p_we[i]  = 1'($urandom_range(0, 1));
               p_mop[i] = ($urandom_range(0, 9) == 0) ? bad_t[$urandom_range(0, 2)]
                                                     : legal_t[$urandom_range(0, 4)];
               offs = int'($urandom_range(0, 63));
               if ($urandom_range(0, 9) == 0)
                  p_addr[i] = (BASE ^ (32'h1 << $urandom_range(17, 31))) + 32'(offs);
               else
                  p_addr[i] = BASE + 32'(offs);
               p_wd[i] = $urandom;
            end
         end
         drive(1'b0, pend[0], p_we[0], p_addr[0], p_wd[0], p_mop[0]);
         drive(1'b1, pend[1], p_we[1], p_addr[1], p_wd[1], p_mop[1]);
         #1;
         // Response from the previous cycle's grant.
         checks++; if (m0_if.rvalid !== (exp_v && !exp_id) || m1_if.rvalid !== (exp_v && exp_id)) begin
            errors++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp_v=%b id=%b", cyc, m0_if.rvalid, m1_if.rvalid, exp_v, exp_id);
         end
         if (exp_v) begin
            checks++; if ((exp_id ? m1_if.err : m0_if.err) !== exp_err) begin
               errors++; $display("FAIL rnd_err c=%0d got=%b exp=%b", cyc, exp_id ? m1_if.err : m0_if.err, exp_err);
            end
            checks++; if ((exp_id ? m1_if.rdata : m0_if.rdata) !== exp_rd) begin
               errors++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", cyc, exp_id ? m1_if.rdata : m0_if.rdata, exp_rd);
            end
         end
         any = pend[0] | pend[1];
         g   = (pend[0] && pend[1]) ? ~last : ~pend[0];
         checks++; if (m0_if.gnt !== (any && !g) || m1_if.gnt !== (any && g)) begin
            errors++; $display("FAIL rnd_gnt c=%0d got=%b%b exp_any=%b id=%b", cyc, m0_if.gnt, m1_if.gnt, any, g);
         end
         if (any) begin
            a = p_addr[g]; m = p_mop[g]; we = p_we[g];
            size  = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
            e_err = (m == 3'b011 || m == 3'b110 || m == 3'b111) ||
                    (a % size != 0) || (a[31:17] != BASE[31:17]);
            checks++; if (mem_we !== (we && !e_err)) begin
               errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", cyc, mem_we, we && !e_err);
            end
            offs = int'(a - BASE);
            val  = '0;
            if (!e_err) begin
               checks++; if (mem_addr !== 15'(offs / 4)) begin
                  errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", cyc, mem_addr, offs / 4);
               end
               if (we) begin
                  checks++; if (mem_byteena !== 4'(((1 << size) - 1) << (offs % 4)) ||
                                mem_wdata !== (p_wd[g] << (8 * (offs % 4)))) begin
                     errors++; $display("FAIL rnd_store c=%0d got=%b/%h", cyc, mem_byteena, mem_wdata);
                  end
                  for (int k = 0; k < size; k++) ref_bytes[offs + k] = p_wd[g][8*k +: 8];
               end else begin
                  for (int k = 0; k < size; k++) val[8*k +: 8] = ref_bytes[offs + k];
                  if (!m[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
                  if (!m[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
               end
            end
            exp_v = 1'b1; exp_id = g; exp_err = e_err; exp_rd = val;
            last = g; pend[g] = 1'b0;
         end else begin
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rnd_idle_we c=%0d got=%b exp=0", cyc, mem_we); end
            exp_v = 1'b0;
         end
      end
      @(negedge clk);
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      q_ovr_en = 1'b1;
      q_ovr    = 32'h0;
      idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_load_word();
      test_store_byte();
      test_halfword();
      test_misalign();
      test_round_robin();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
